// File: rtl/store_buffer_if.sv
// Bundle of cpu-side and dmem-side signals around the store buffer.
// The buffer takes the slave view; whatever drives the cpu and dmem side takes the master view.
interface store_buffer_if #(
    parameter int AW = 32
);
    logic [AW-1:0] cpu_daddr;
    logic [31:0]   cpu_dwdata;
    logic [3:0]    cpu_dwe;
    logic          cpu_dre;
    logic [31:0]   cpu_drdata;
    logic          cpu_stall;
    logic [AW-1:0] mem_daddr;
    logic [31:0]   mem_dwdata;
    logic [3:0]    mem_dwe;
    logic [31:0]   mem_drdata;
    logic          mem_ready;
    logic          sb_empty;

    modport slave (
        input  cpu_daddr, cpu_dwdata, cpu_dwe, cpu_dre, mem_drdata, mem_ready,
        output cpu_drdata, cpu_stall, mem_daddr, mem_dwdata, mem_dwe, sb_empty
    );

    modport master (
        output cpu_daddr, cpu_dwdata, cpu_dwe, cpu_dre, mem_drdata, mem_ready,
        input  cpu_drdata, cpu_stall, mem_daddr, mem_dwdata, mem_dwe, sb_empty
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer between cpu data port and dmem: stores queue in a circular FIFO,
// retire in non-load cycles, and loads see pending bytes through per-lane forwarding.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-3:0]  addr_q [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [3:0]     mask_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [PW-1:0]  young;
    logic [CW-1:0]  count_q, count_d;

    logic           load, store, drain, coalesce, stall, enqueue;
    logic [AW-3:0]  req_waddr;

    assign req_waddr = bus.cpu_daddr[AW-1:2];

    always_comb begin
        load     = bus.cpu_dre && (bus.cpu_dwe == 4'b0000);
        store    = (bus.cpu_dwe != 4'b0000);
        young    = tail_q - 1'b1;
        // Gating with reset keeps dmem untouched in a reset cycle with entries still pending.
        drain    = !reset && (count_q != '0) && bus.mem_ready && !load;
        coalesce = store && (count_q != '0) && (addr_q[young] == req_waddr)
                   && !(drain && (young == head_q));
        stall    = !reset && store && !coalesce && (count_q == FULL) && !drain;
        enqueue  = store && !coalesce && !stall;
        head_d   = drain   ? head_q + 1'b1 : head_q;
        tail_d   = enqueue ? tail_q + 1'b1 : tail_q;
        count_d  = count_q + CW'(enqueue) - CW'(drain);
    end

    always_comb begin
        bus.mem_daddr  = bus.cpu_daddr;
        bus.mem_dwdata = data_q[head_q];
        bus.mem_dwe    = 4'b0000;
        if (load) begin
            bus.mem_daddr = {req_waddr, 2'b00};
        end else if (drain) begin
            bus.mem_daddr = {addr_q[head_q], 2'b00};
            bus.mem_dwe   = mask_q[head_q];
        end
    end

    assign bus.cpu_stall = stall;
    assign bus.sb_empty  = (count_q == '0);

    // Walk entries oldest to youngest so the youngest matching byte wins per lane.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0]    lane_byte;
        logic [PW-1:0] idx;
        always_comb begin
            lane_byte = bus.mem_drdata[8*gi +: 8];
            idx       = head_q;
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + PW'(i);
                if (valid_q[idx] && (addr_q[idx] == req_waddr) && mask_q[idx][gi]) begin
                    lane_byte = data_q[idx][8*gi +: 8];
                end
            end
        end
    end

    assign bus.cpu_drdata = {g_lane[3].lane_byte, g_lane[2].lane_byte,
                             g_lane[1].lane_byte, g_lane[0].lane_byte};

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (drain) begin
                valid_q[head_q] <= 1'b0;
            end
            // When full, tail equals head: the new entry's valid must win over the drain clear.
            if (enqueue) begin
                valid_q[tail_q] <= 1'b1;
            end
        end
    end

    // Payload needs no reset; valid_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enqueue) begin
            addr_q[tail_q] <= req_waddr;
            data_q[tail_q] <= bus.cpu_dwdata;
            mask_q[tail_q] <= bus.cpu_dwe;
        end else if (coalesce) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.cpu_dwe[b]) begin
                    data_q[young][8*b +: 8] <= bus.cpu_dwdata[8*b +: 8];
                end
            end
            mask_q[young] <= mask_q[young] | bus.cpu_dwe;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios then random traffic, all checked against a
// queue-of-pending-stores model plus a reference copy of dmem.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    typedef struct {
        logic [5:0]  w;
        logic [31:0] d;
        logic [3:0]  m;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic mem_clr;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] dmem [64];
    logic [31:0] refm [64];
    ent_t        q [$];

    always #5 clk = ~clk;

    store_buffer_if #(.AW(AW)) sbif ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sbif.slave)
    );

    assign sbif.mem_drdata = dmem[sbif.mem_daddr[7:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (sbif.mem_dwe[b]) dmem[sbif.mem_daddr[7:2]][8*b +: 8] <= sbif.mem_dwdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // One cycle: drive inputs, check outputs at the falling edge, then advance the model.
    task automatic step(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input logic re, input logic rdy);
        logic ld, st, dr, co, stl;
        logic [31:0] fw;
        ent_t e;
        sbif.cpu_daddr  = {24'h0, a};
        sbif.cpu_dwdata = wd;
        sbif.cpu_dwe    = we;
        sbif.cpu_dre    = re;
        sbif.mem_ready  = rdy;
        @(negedge clk);
        ld  = re && (we == 4'b0);
        st  = (we != 4'b0);
        dr  = (q.size() > 0) && rdy && !ld;
        co  = st && (q.size() > 0) && (q[q.size()-1].w == a[7:2]) && !(dr && q.size() == 1);
        stl = st && !co && (q.size() == DEPTH) && !dr;
        chk("sb_empty", 32'(sbif.sb_empty), 32'(q.size() == 0));
        chk("cpu_stall", 32'(sbif.cpu_stall), 32'(stl));
        if (dr) begin
            chk("drain_dwe", 32'(sbif.mem_dwe), 32'(q[0].m));
            chk("drain_addr", sbif.mem_daddr, {24'h0, q[0].w, 2'b00});
            chk("drain_data", sbif.mem_dwdata & lanes(q[0].m), q[0].d & lanes(q[0].m));
        end else begin
            chk("idle_dwe", 32'(sbif.mem_dwe), 32'h0);
        end
        if (ld) begin
            fw = refm[a[7:2]];
            foreach (q[k]) begin
                if (q[k].w == a[7:2]) fw = (fw & ~lanes(q[k].m)) | (q[k].d & lanes(q[k].m));
            end
            chk("load_data", sbif.cpu_drdata, fw);
            chk("load_addr", sbif.mem_daddr, {24'h0, a[7:2], 2'b00});
        end
        if (dr) begin
            refm[q[0].w] = (refm[q[0].w] & ~lanes(q[0].m)) | (q[0].d & lanes(q[0].m));
            void'(q.pop_front());
        end
        if (co) begin
            e = q[q.size()-1];
            e.d = (e.d & ~lanes(we)) | (wd & lanes(we));
            e.m = e.m | we;
            q[q.size()-1] = e;
        end else if (st && !stl) begin
            e.w = a[7:2];
            e.d = wd;
            e.m = we;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic clr);
        reset           = 1'b1;
        mem_clr         = clr;
        sbif.cpu_daddr  = 32'h0;
        sbif.cpu_dwdata = 32'hCAFEF00D;
        sbif.cpu_dwe    = 4'hF;
        sbif.cpu_dre    = 1'b0;
        sbif.mem_ready  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_mem_dwe", 32'(sbif.mem_dwe), 32'h0);
            chk("rst_stall", 32'(sbif.cpu_stall), 32'h0);
            @(posedge clk);
            #1;
            mem_clr = 1'b0;
            chk("rst_sb_empty", 32'(sbif.sb_empty), 32'h1);
        end
        reset        = 1'b0;
        sbif.cpu_dwe = 4'h0;
        q.delete();
    endtask

    task automatic drain_all();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (q.size() == 0) break;
            step(8'h00, 32'h0, 4'h0, 1'b0, 1'b1);
        end
        chk("drained_sb_empty", 32'(sbif.sb_empty), 32'h1);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  we;
        int          kind;
        logic        rdy;
        for (int i = 0; i < 64; i++) refm[i] = '0;
        do_reset(3, 1'b1);
        chk("reset_dmem0", dmem[0], 32'h0);

        // Forwarding of a full word, then drain in the first non-load cycle.
        step(8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
        step(8'h10, 32'h0, 4'h0, 1'b1, 1'b1);
        chk("no_write_on_load", dmem[4], 32'h0);
        step(8'h00, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("dmem_10", dmem[4], 32'hDEADBEEF);

        // Byte coalescing into one entry.
        step(8'h20, 32'h000000AA, 4'b0001, 1'b0, 1'b1);
        step(8'h20, 32'h00BB0000, 4'b0100, 1'b0, 1'b0);
        step(8'h20, 32'h0, 4'h0, 1'b1, 1'b1);
        step(8'h00, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("dmem_20", dmem[8], 32'h00BB00AA);
        chk("coalesced_empty", 32'(sbif.sb_empty), 32'h1);

        // Fill, stall while dmem is busy, then release.
        step(8'h00, 32'hA0A0A0A0, 4'hF, 1'b0, 1'b0);
        step(8'h04, 32'hA1A1A1A1, 4'hF, 1'b0, 1'b0);
        step(8'h08, 32'hA2A2A2A2, 4'hF, 1'b0, 1'b0);
        step(8'h0C, 32'hA3A3A3A3, 4'hF, 1'b0, 1'b0);
        step(8'h40, 32'hA4A4A4A4, 4'hF, 1'b0, 1'b0);
        step(8'h40, 32'hA4A4A4A4, 4'hF, 1'b0, 1'b0);
        step(8'h40, 32'hA4A4A4A4, 4'hF, 1'b0, 1'b1);
        drain_all();
        chk("dmem_00", dmem[0], 32'hA0A0A0A0);
        chk("dmem_40", dmem[16], 32'hA4A4A4A4);

        // Youngest-entry forwarding across separate entries of the same word.
        step(8'h30, 32'h11111111, 4'hF, 1'b0, 1'b0);
        step(8'h34, 32'h33333333, 4'hF, 1'b0, 1'b0);
        step(8'h30, 32'h00000022, 4'b0001, 1'b0, 1'b0);
        step(8'h30, 32'h0, 4'h0, 1'b1, 1'b1);
        drain_all();
        chk("dmem_30", dmem[12], 32'h11111122);

        // Reset with pending stores discards them.
        step(8'h50, 32'h55555555, 4'hF, 1'b0, 1'b0);
        step(8'h54, 32'h66666666, 4'hF, 1'b0, 1'b0);
        do_reset(1, 1'b0);
        step(8'h00, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("discard_50", dmem[20], 32'h0);
        chk("discard_54", dmem[21], 32'h0);

        // Random mix of stores, loads and idles with an unreliable mem_ready.
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 2));
            a    = 8'($urandom_range(24, 31) * 4 + $urandom_range(0, 3));
            wd   = $urandom();
            we   = 4'($urandom_range(1, 15));
            rdy  = ($urandom_range(0, 3) != 0);
            if (kind == 0)      step(a, wd, we, 1'b0, rdy);
            else if (kind == 1) step(a, 32'h0, 4'h0, 1'b1, rdy);
            else                step(a, 32'h0, 4'h0, 1'b0, rdy);
        end
        drain_all();
        for (int i = 0; i < 64; i++) chk($sformatf("dmem[%0d]", i), dmem[i], refm[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
